// File: rtl/bist_pattern_gen.sv
// Multi-mode BIST address/data sequencer (checkerboard, March C-, solid) for a single-port SRAM.
// Outputs decode registered state directly; cen=0 freezes the sequencer with the current op held.
module bist_pattern_gen #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] BASE_CB = {DATA_WIDTH/2{2'b01}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  cen,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] exp_data,
  output logic                  we,
  output logic                  re,
  output logic [2:0]            elem,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] MODE_CB    = 2'd0;
  localparam logic [1:0] MODE_MARCH = 2'd1;

  state_t                  state_q, state_d;
  logic [1:0]              mode_q;
  logic [2:0]              elem_q;
  logic                    op_q;
  logic [ADDR_WIDTH-1:0]   addr_q;

  logic                    two_ops, op_wr, op_val, last_elem, desc;
  logic                    last_op, last_addr, advance, finish, accept;
  logic [1:0]              mode_eff;
  logic [DATA_WIDTH-1:0]   op_data;

  // Only March C- elements 3 and 4 walk the array downwards.
  function automatic logic is_desc(input logic [1:0] m, input logic [2:0] e);
    return (m == MODE_MARCH) && ((e == 3'd3) || (e == 3'd4));
  endfunction

  always_comb begin
    two_ops   = 1'b0;
    op_wr     = 1'b0;
    op_val    = 1'b0;
    last_elem = 1'b0;
    if (mode_q == MODE_MARCH) begin
      last_elem = (elem_q == 3'd5);
      two_ops   = (elem_q != 3'd0) && (elem_q != 3'd5);
      if (elem_q == 3'd0) begin
        op_wr = 1'b1;
      end else if (elem_q != 3'd5) begin
        // Elements 1..4 read the old value then write its complement.
        op_wr  = op_q;
        op_val = ((elem_q == 3'd2) || (elem_q == 3'd4)) ^ op_q;
      end
    end else begin
      last_elem = (elem_q == 3'd3);
      op_wr     = ~elem_q[0];
      op_val    = elem_q[1];
    end
  end

  assign desc      = is_desc(mode_q, elem_q);
  assign op_data   = (mode_q == MODE_CB) ? (BASE_CB ^ {DATA_WIDTH{addr_q[0] ^ op_val}})
                                         : {DATA_WIDTH{op_val}};
  assign last_op   = two_ops ? op_q : 1'b1;
  assign last_addr = desc ? (addr_q == '0) : (addr_q == '1);
  assign advance   = (state_q == RUN) && cen;
  assign finish    = advance && last_op && last_addr && last_elem;
  assign accept    = (state_q != RUN) && start;
  assign mode_eff  = (mode == 2'd3) ? MODE_CB : mode;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (finish) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 2'd0;
      elem_q <= 3'd0;
      op_q   <= 1'b0;
      addr_q <= '0;
    end else if (accept) begin
      mode_q <= mode_eff;
      elem_q <= 3'd0;
      op_q   <= 1'b0;
      addr_q <= is_desc(mode_eff, 3'd0) ? '1 : '0;
    end else if (advance) begin
      if (!last_op) begin
        op_q <= 1'b1;
      end else begin
        op_q <= 1'b0;
        if (!last_addr) begin
          addr_q <= desc ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
        end else if (!last_elem) begin
          elem_q <= elem_q + 3'd1;
          addr_q <= is_desc(mode_q, elem_q + 3'd1) ? '1 : '0;
        end
      end
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign we       = busy & op_wr;
  assign re       = busy & ~op_wr;
  assign wdata    = we ? op_data : '0;
  assign exp_data = re ? op_data : '0;
  assign addr     = busy ? addr_q : '0;
  assign elem     = busy ? elem_q : 3'd0;

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Directed table-driven bench for bist_pattern_gen (AW=8, DW=4): op-indexed vectors per mode plus
// sequences for stall, ignored start, restart from DONE and asynchronous reset mid-run.
module tb_bist_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n, start, cen;
  logic [1:0] mode;
  logic [7:0] addr;
  logic [3:0] wdata, exp_data;
  logic       we, re, busy, done;
  logic [2:0] elem;

  int n_cmp  = 0;
  int n_fail = 0;

  bist_pattern_gen #(.ADDR_WIDTH(8), .DATA_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .cen(cen),
    .addr(addr), .wdata(wdata), .exp_data(exp_data), .we(we), .re(re),
    .elem(elem), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] mode;
    int         op;
    logic [20:0] exp;  // {addr, we, re, wdata, exp_data, elem}
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input string n, input logic [1:0] m, input int op,
                              input logic [7:0] a, input logic w, input logic r,
                              input logic [3:0] wd, input logic [3:0] ex, input logic [2:0] el);
    vec_t v;
    v.name = n; v.mode = m; v.op = op; v.exp = {a, w, r, wd, ex, el};
    return v;
  endfunction

  function automatic logic [20:0] obs();
    return {addr, we, re, wdata, exp_data, elem};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic run(input logic [1:0] m, input int total, input int inj_at,
                     input int rst_at, input bit rnd);
    int          cnt = 0;
    int          cyc = 0;
    bit          busy_bad = 1'b0;
    bit          stall_bad = 1'b0;
    logic [7:0]  elem_mask = 8'h00;
    logic [22:0] prev;
    logic [1:0]  em;
    em = (m == 2'd3) ? 2'd0 : m;
    start = 1'b1; mode = m; cen = 1'b1;
    tick();
    start = 1'b0; mode = 2'd0;
    cmp("start_busy_done", {busy, done}, 2'b10);
    while (cnt < total && cyc < 8000) begin
      if (!busy || done || (we == re)) busy_bad = 1'b1;
      elem_mask[elem] = 1'b1;
      foreach (vecs[k])
        if (vecs[k].mode == em && vecs[k].op == cnt) cmp(vecs[k].name, obs(), vecs[k].exp);
      if (cnt == rst_at) begin
        rst_n = 1'b0;
        #1;
        cmp("async_reset_outputs", {obs(), busy, done}, 0);
        start = 1'b1;
        tick();
        cmp("start_ignored_in_reset", {obs(), busy, done}, 0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        cmp("idle_after_reset", {obs(), busy, done}, 0);
        return;
      end
      cen = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cnt == inj_at) begin
        start = 1'b1; mode = 2'd2;
      end
      prev = {obs(), busy, done};
      tick();
      cyc++;
      start = 1'b0;
      if (cen) cnt++;
      else if ({obs(), busy, done} !== prev) stall_bad = 1'b1;
    end
    cen = 1'b1;
    cmp("done_after_last_op", {busy, done, we, re}, 4'b0100);
    cmp("busy_exclusive_we_re", 32'(busy_bad), 0);
    cmp("elem_sequence", elem_mask, (total == 2560) ? 8'h3F : 8'h0F);
    if (rnd) cmp("stall_holds_outputs", 32'(stall_bad), 0);
    tick();
    cmp("done_level_held", {busy, done, obs()}, {2'b01, 21'd0});
  endtask

  initial begin
    vecs[0]  = mk("cb_op0",      2'd0, 0,    8'd0,   1, 0, 4'b0101, 4'h0, 3'd0);
    vecs[1]  = mk("cb_op1",      2'd0, 1,    8'd1,   1, 0, 4'b1010, 4'h0, 3'd0);
    vecs[2]  = mk("cb_op255",    2'd0, 255,  8'd255, 1, 0, 4'b1010, 4'h0, 3'd0);
    vecs[3]  = mk("cb_op256",    2'd0, 256,  8'd0,   0, 1, 4'h0, 4'b0101, 3'd1);
    vecs[4]  = mk("cb_op257",    2'd0, 257,  8'd1,   0, 1, 4'h0, 4'b1010, 3'd1);
    vecs[5]  = mk("cb_op512",    2'd0, 512,  8'd0,   1, 0, 4'b1010, 4'h0, 3'd2);
    vecs[6]  = mk("cb_op513",    2'd0, 513,  8'd1,   1, 0, 4'b0101, 4'h0, 3'd2);
    vecs[7]  = mk("cb_op1023",   2'd0, 1023, 8'd255, 0, 1, 4'h0, 4'b0101, 3'd3);
    vecs[8]  = mk("mc_op0",      2'd1, 0,    8'd0,   1, 0, 4'h0, 4'h0, 3'd0);
    vecs[9]  = mk("mc_op256",    2'd1, 256,  8'd0,   0, 1, 4'h0, 4'h0, 3'd1);
    vecs[10] = mk("mc_op257",    2'd1, 257,  8'd0,   1, 0, 4'hF, 4'h0, 3'd1);
    vecs[11] = mk("mc_op767",    2'd1, 767,  8'd255, 1, 0, 4'hF, 4'h0, 3'd1);
    vecs[12] = mk("mc_op768",    2'd1, 768,  8'd0,   0, 1, 4'h0, 4'hF, 3'd2);
    vecs[13] = mk("mc_op769",    2'd1, 769,  8'd0,   1, 0, 4'h0, 4'h0, 3'd2);
    vecs[14] = mk("mc_op1280",   2'd1, 1280, 8'd255, 0, 1, 4'h0, 4'h0, 3'd3);
    vecs[15] = mk("mc_op1281",   2'd1, 1281, 8'd255, 1, 0, 4'hF, 4'h0, 3'd3);
    vecs[16] = mk("mc_op1282",   2'd1, 1282, 8'd254, 0, 1, 4'h0, 4'h0, 3'd3);
    vecs[17] = mk("mc_op1792",   2'd1, 1792, 8'd255, 0, 1, 4'h0, 4'hF, 3'd4);
    vecs[18] = mk("mc_op2303",   2'd1, 2303, 8'd0,   1, 0, 4'h0, 4'h0, 3'd4);
    vecs[19] = mk("mc_op2304",   2'd1, 2304, 8'd0,   0, 1, 4'h0, 4'h0, 3'd5);
    vecs[20] = mk("mc_op2559",   2'd1, 2559, 8'd255, 0, 1, 4'h0, 4'h0, 3'd5);
    vecs[21] = mk("solid_op0",   2'd2, 0,    8'd0,   1, 0, 4'h0, 4'h0, 3'd0);
    vecs[22] = mk("solid_op256", 2'd2, 256,  8'd0,   0, 1, 4'h0, 4'h0, 3'd1);
    vecs[23] = mk("solid_op512", 2'd2, 512,  8'd0,   1, 0, 4'hF, 4'h0, 3'd2);
    vecs[24] = mk("solid_op1023",2'd2, 1023, 8'd255, 0, 1, 4'h0, 4'hF, 3'd3);

    rst_n = 1'b0; start = 1'b1; cen = 1'b1; mode = 2'd0;
    #1;
    repeat (3) tick();
    cmp("reset_outputs", {obs(), busy, done}, 0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    cmp("idle_after_release", {obs(), busy, done}, 0);

    run(2'd0, 1024, -1, -1, 1'b0);   // checkerboard
    run(2'd1, 2560, 300, -1, 1'b0);  // March C- with start pulse mid-run
    run(2'd2, 1024, -1, -1, 1'b1);   // solid, restart from DONE, random stalls
    run(2'd0, 1024, -1, 700, 1'b0);  // reset mid-run
    run(2'd3, 1024, -1, -1, 1'b0);   // reserved mode behaves as checkerboard

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
